// File: rtl/hilo_unit.sv
// HI/LO register stage: holds multiply/divide results in flight for a fixed latency,
// then commits them to HI/LO; also services move-to / move-from HI/LO.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] alu_res1,
  input  logic [31:0] alu_res2,
  input  logic [31:0] rs_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   pend_hi_reg, pend_hi_next;
  logic [31:0]   pend_lo_reg, pend_lo_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic          rd_valid_reg, rd_valid_next;
  logic [31:0]   rd_data_reg, rd_data_next;

  logic hilo_op;
  logic accept;

  // Ops 6/7 are no-ops: they never stall and never act.
  assign hilo_op = op_valid && (op <= OP_MFLO);
  assign busy    = (state_reg == BUSY);
  assign stall   = hilo_op && busy && !flush;
  assign accept  = hilo_op && !busy && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      pend_hi_reg  <= '0;
      pend_lo_reg  <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      pend_hi_reg  <= pend_hi_next;
      pend_lo_reg  <= pend_lo_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    pend_hi_next  = pend_hi_reg;
    pend_lo_next  = pend_lo_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    rd_valid_next = 1'b0;
    rd_data_next  = rd_data_reg;

    if (flush) begin
      // Kill wins over a same-cycle commit: HI/LO keep their old values.
      state_next   = IDLE;
      count_next   = '0;
      pend_hi_next = '0;
      pend_lo_next = '0;
    end else if (state_reg == BUSY) begin
      if (count_reg == '0) begin
        hi_next    = pend_hi_reg;
        lo_next    = pend_lo_reg;
        state_next = IDLE;
      end else begin
        count_next = count_reg - 1'b1;
      end
    end else if (accept) begin
      case (op)
        OP_MUL, OP_DIV: begin
          pend_lo_next = alu_res1;
          pend_hi_next = alu_res2;
          count_next   = (op == OP_MUL) ? MUL_CNT : DIV_CNT;
          state_next   = BUSY;
        end
        OP_MTHI: hi_next = rs_data;
        OP_MTLO: lo_next = rs_data;
        OP_MFHI: begin
          rd_valid_next = 1'b1;
          rd_data_next  = hi_reg;
        end
        OP_MFLO: begin
          rd_valid_next = 1'b1;
          rd_data_next  = lo_reg;
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

endmodule
